refund_sequencer: RTL and testbench
===================================

Name: refund_sequencer

Overview:
- Credit/refund controller for the vending datapath.
- Accumulates coin credit and services buy requests against a price.
- On the falling edge of the refund switch, returns the remaining credit as a timed sequence of coin-eject pulses (greedy: quarter, dime, nickel).
- The eject solenoid drivers consume its outputs directly.

Parameters:
- CREDIT_W, 6: width of credit and price, in nickel units (5 cents); max credit is 2^CREDIT_W-1.
- PULSE_TICKS, 2: cycles each eject output is held high (>=1).
- GAP_TICKS, 2: low cycles between consecutive eject pulses (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- nickel  in  1  one-cycle pulse, coin worth 1 unit
- dime  in  1  one-cycle pulse, coin worth 2 units
- quarter  in  1  one-cycle pulse, coin worth 5 units
- refund  in  1  refund switch level (synchronous to clk)
- buy  in  1  one-cycle purchase request
- price  in  CREDIT_W  item price in units, sampled on buy
- credit  out  CREDIT_W  current credit (registered)
- vend  out  1  one-cycle dispense pulse
- short_funds  out  1  one-cycle pulse: buy rejected, credit < price
- coin_bounce  out  1  one-cycle pulse: an inserted coin was not accepted
- eject_q, eject_d, eject_n  out  1 each  coin eject drives, held PULSE_TICKS
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): state IDLE, credit=0, refund history=0, pending refund=0; all outputs 0.
- Refund trigger:
  - refund is registered once (refund_prev).
  - A falling edge (refund_prev & ~refund) sets pending_refund.
  - pending_refund is serviced only from IDLE and is cleared when serviced.
  - A falling edge in any state is latched, never lost.
- States:
  - IDLE, VEND, EJECT, GAP. All outputs are registered, so vend, short_funds and coin_bounce appear 1 cycle after the causing input.
- IDLE, in priority order:
  - (a) buy:
    - If credit >= price: credit <= credit-price, next state VEND.
    - Else: short_funds pulse, stay IDLE.
    - Any coin in the same cycle is bounced.
  - (b) pending_refund:
    - If credit > 0: next state EJECT.
    - If credit == 0: clear pending_refund, stay IDLE.
    - Any coin in the same cycle is bounced.
  - (c) Coin accept:
    - Simultaneous coins resolve quarter > dime > nickel; only the highest is accepted, the others cause coin_bounce.
    - If credit+value would exceed 2^CREDIT_W-1, that coin is bounced and credit is unchanged.
- VEND: vend=1 for exactly one cycle, then IDLE.
- EJECT entry, coin selection:
  - credit >= 5: eject_q, credit -= 5.
  - Else credit >= 2: eject_d, credit -= 2.
  - Else: eject_n, credit -= 1.
  - Credit is decremented on entry; exactly one eject output is high for PULSE_TICKS cycles.
- GAP:
  - All ejects low for GAP_TICKS cycles.
  - Then EJECT if credit > 0, else IDLE. pending_refund is cleared on return to IDLE.
- Busy states: any coin in VEND/EJECT/GAP is bounced; buy is ignored with no pulse.
- Tick counter: single down-counter, width clog2(max(PULSE_TICKS,GAP_TICKS))+1, reloaded on each state entry.
- Reset mid-sequence: ejects drop asynchronously and remaining credit is discarded.

Optional Feature:
- Macro: AUTO_CHANGE_EN.
- Defined: after VEND, if the remaining credit > 0, the FSM goes directly to EJECT and returns the change without a refund edge; a latched pending_refund is cleared at the end of that sequence.
- Undefined: VEND always returns to IDLE and change is returned only on a refund falling edge.

Test Plan:
- Reset, then quarter, dime, nickel on separate cycles -> credit=8, no bounce.
- Credit=8, refund 1->0 (PULSE_TICKS=2, GAP_TICKS=2) -> eject_q high 2 cycles, gap 2, eject_d 2, gap 2, eject_n 2, gap 2, IDLE, credit=0; busy high throughout.
- Credit=3, buy with price=5 -> short_funds one cycle, credit stays 3; buy with price=3 -> vend one cycle, credit=0.
- quarter and nickel in the same cycle -> credit += 5, coin_bounce one cycle. Credit=62 (CREDIT_W=6) plus a dime -> bounce, credit stays 62.
- Refund edge while in VEND -> after VEND, refund sequence starts. A coin during EJECT -> coin_bounce, credit unaffected.
- Assert reset during an eject_q pulse -> eject_q low immediately, credit=0, IDLE. With AUTO_CHANGE_EN: credit=7, buy price=2 -> vend, then eject_q with no refund toggle.

Source files
------------

// File: rtl/refund_sequencer.sv
// refund_sequencer -- credit / refund controller for the vending datapath.
//
// Accumulates coin credit (in nickel units), services buy requests against a
// price, and on a falling edge of the refund switch pays the remaining credit
// back as a timed train of eject pulses, largest coin first.
//
// Optional build macro: AUTO_CHANGE_EN
//   defined   : after a vend with credit left over, change is ejected at once
//   undefined : change is only returned on a refund falling edge
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   nickel/dime/quarter one-cycle coin pulses worth 1 / 2 / 5 units
//   refund              refund switch level (synchronous to clk)
//   buy, price          one-cycle purchase request, price sampled with it
//   credit              current credit (registered)
//   vend                one-cycle dispense pulse
//   short_funds         one-cycle pulse, buy rejected for lack of credit
//   coin_bounce         one-cycle pulse, an inserted coin was not accepted
//   eject_q/d/n         eject solenoid drives, each pulse PULSE_TICKS long
//   busy                high whenever the controller is not idle
module refund_sequencer #(
  parameter int CREDIT_W    = 6,
  parameter int PULSE_TICKS = 2,
  parameter int GAP_TICKS   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                refund,
  input  logic                buy,
  input  logic [CREDIT_W-1:0] price,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                short_funds,
  output logic                coin_bounce,
  output logic                eject_q,
  output logic                eject_d,
  output logic                eject_n,
  output logic                busy
);

  localparam int TICK_MAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX) + 1;

  localparam logic [TICK_W-1:0] PULSE_LOAD = TICK_W'(PULSE_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LOAD   = TICK_W'(GAP_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);

  // Coin values in credit width, and one bit wider for overflow detection.
  localparam logic [CREDIT_W-1:0] VAL_Q = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] VAL_D = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] VAL_N = CREDIT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VEND  = 2'd1,
    EJECT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [CREDIT_W-1:0] credit_next;
  logic [TICK_W-1:0]   tick, tick_next;
  logic                refund_prev;
  logic                pending, pending_next;
  logic                vend_next, short_next, bounce_next, busy_next;
  logic                eject_q_next, eject_d_next, eject_n_next;

  logic                fall;
  logic                any_coin, multi_coin;
  logic [CREDIT_W:0]   coin_value;
  logic [CREDIT_W:0]   coin_sum;
  logic                enter_eject;
  logic                clear_pending;

  assign fall       = refund_prev & ~refund;
  assign any_coin   = nickel | dime | quarter;
  assign multi_coin = (quarter & (dime | nickel)) | (dime & nickel);

  // Only the most valuable simultaneous coin is considered for acceptance.
  always_comb begin
    coin_value = '0;
    if (quarter)     coin_value = {1'b0, VAL_Q};
    else if (dime)   coin_value = {1'b0, VAL_D};
    else if (nickel) coin_value = {1'b0, VAL_N};
  end

  // Max credit is all ones, so any carry out means the coin would overflow.
  assign coin_sum = {1'b0, credit} + coin_value;

  always_comb begin
    state_next    = state;
    credit_next   = credit;
    tick_next     = (tick != '0) ? tick - TICK_ONE : tick;
    short_next    = 1'b0;
    bounce_next   = 1'b0;
    enter_eject   = 1'b0;
    clear_pending = 1'b0;
    eject_q_next  = 1'b0;
    eject_d_next  = 1'b0;
    eject_n_next  = 1'b0;

    case (state)
      IDLE: begin
        if (buy) begin
          bounce_next = any_coin;
          if (credit >= price) begin
            credit_next = credit - price;
            state_next  = VEND;
            tick_next   = '0;
          end else begin
            short_next = 1'b1;
          end
        end else if (pending) begin
          bounce_next   = any_coin;
          clear_pending = 1'b1;
          if (credit != '0) enter_eject = 1'b1;
        end else if (any_coin) begin
          bounce_next = multi_coin | coin_sum[CREDIT_W];
          if (!coin_sum[CREDIT_W]) credit_next = coin_sum[CREDIT_W-1:0];
        end
      end

      VEND: begin
        bounce_next = any_coin;
`ifdef AUTO_CHANGE_EN
        if (credit != '0) enter_eject = 1'b1;
        else              state_next  = IDLE;
`else
        state_next = IDLE;
`endif
      end

      EJECT: begin
        bounce_next = any_coin;
        if (tick == '0) begin
          state_next = GAP;
          tick_next  = GAP_LOAD;
        end
      end

      GAP: begin
        bounce_next = any_coin;
        if (tick == '0) begin
          if (credit != '0) begin
            enter_eject = 1'b1;
          end else begin
            state_next    = IDLE;
            clear_pending = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // Greedy coin choice happens on every EJECT entry; credit drops at entry
    // so the credit output already shows what remains after this coin.
    if (enter_eject) begin
      state_next = EJECT;
      tick_next  = PULSE_LOAD;
      if (credit >= VAL_Q) begin
        eject_q_next = 1'b1;
        credit_next  = credit - VAL_Q;
      end else if (credit >= VAL_D) begin
        eject_d_next = 1'b1;
        credit_next  = credit - VAL_D;
      end else begin
        eject_n_next = 1'b1;
        credit_next  = credit - VAL_N;
      end
    end else if (state_next == EJECT) begin
      eject_q_next = eject_q;
      eject_d_next = eject_d;
      eject_n_next = eject_n;
    end

    vend_next = (state_next == VEND);
    busy_next = (state_next != IDLE);

    // A new falling edge always wins over a clear in the same cycle.
    pending_next = (pending & ~clear_pending) | fall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      tick        <= '0;
      refund_prev <= 1'b0;
      pending     <= 1'b0;
      vend        <= 1'b0;
      short_funds <= 1'b0;
      coin_bounce <= 1'b0;
      eject_q     <= 1'b0;
      eject_d     <= 1'b0;
      eject_n     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      credit      <= credit_next;
      tick        <= tick_next;
      refund_prev <= refund;
      pending     <= pending_next;
      vend        <= vend_next;
      short_funds <= short_next;
      coin_bounce <= bounce_next;
      eject_q     <= eject_q_next;
      eject_d     <= eject_d_next;
      eject_n     <= eject_n_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_refund_sequencer.sv
// Self-checking bench for refund_sequencer (default parameters:
// CREDIT_W=6, PULSE_TICKS=2, GAP_TICKS=2). A transaction-level model predicts
// the outputs; a negedge process compares them every cycle, and directed
// steps add hand-computed literal checks.
module tb_refund_sequencer;

  localparam int CW    = 6;
  localparam int PULSE = 2;
  localparam int GAP   = 2;
  localparam int MAXC  = 63;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          nickel = 1'b0, dime = 1'b0, quarter = 1'b0;
  logic          refund = 1'b0, buy = 1'b0;
  logic [CW-1:0] price = '0;
  logic [CW-1:0] credit;
  logic          vend, short_funds, coin_bounce;
  logic          eject_q, eject_d, eject_n, busy;

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b0;

  refund_sequencer #(.CREDIT_W(CW), .PULSE_TICKS(PULSE), .GAP_TICKS(GAP)) dut (
    .clk(clk), .reset(reset), .nickel(nickel), .dime(dime), .quarter(quarter),
    .refund(refund), .buy(buy), .price(price), .credit(credit), .vend(vend),
    .short_funds(short_funds), .coin_bounce(coin_bounce), .eject_q(eject_q),
    .eject_d(eject_d), .eject_n(eject_n), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [CW-1:0] credit;
    logic vend, short_f, bounce, eq, ed, en, busy;
  } out_t;

  out_t cur = '0;
  out_t fq[$];
  int   m_credit = 0;
  bit   m_pend = 0, m_prev = 0, m_seq_ej = 0;

`ifdef AUTO_CHANGE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // Expand a vend and/or a greedy refund of m_credit into per-cycle frames.
  task automatic push_seq(input bit v, input bit ej);
    out_t f;
    int c, val;
    c = m_credit;
    if (v) begin
      f = '0; f.vend = 1; f.busy = 1; f.credit = CW'(c);
      fq.push_back(f);
    end
    if (ej) begin
      while (c > 0) begin
        val = (c >= 5) ? 5 : (c >= 2) ? 2 : 1;
        c -= val;
        for (int i = 0; i < PULSE; i++) begin
          f = '0; f.busy = 1; f.credit = CW'(c);
          f.eq = (val == 5); f.ed = (val == 2); f.en = (val == 1);
          fq.push_back(f);
        end
        for (int i = 0; i < GAP; i++) begin
          f = '0; f.busy = 1; f.credit = CW'(c);
          fq.push_back(f);
        end
      end
    end
    m_credit = c;
    m_seq_ej = ej;
  endtask

  always @(posedge clk or posedge reset) begin
    out_t nxt;
    bit fall, clr, b, s;
    int ncoin, v;
    if (reset) begin
      m_credit = 0; m_pend = 0; m_prev = 0; m_seq_ej = 0;
      fq.delete();
      cur = '0;
    end else begin
      fall  = m_prev & ~refund;
      m_prev = refund;
      clr = 0; b = 0; s = 0;
      nxt = '0;
      ncoin = int'(nickel) + int'(dime) + int'(quarter);
      if (cur.busy) begin
        b = (ncoin != 0);
        if (fq.size() > 0) nxt = fq.pop_front();
        else begin
          nxt.credit = CW'(m_credit);
          if (m_seq_ej) clr = 1;
        end
      end else if (buy) begin
        b = (ncoin != 0);
        if (m_credit >= int'(price)) begin
          m_credit -= int'(price);
          push_seq(1, AUTO && m_credit > 0);
          nxt = fq.pop_front();
        end else begin
          s = 1;
          nxt.credit = CW'(m_credit);
        end
      end else if (m_pend) begin
        b = (ncoin != 0);
        clr = 1;
        if (m_credit > 0) begin
          push_seq(0, 1);
          nxt = fq.pop_front();
        end else nxt.credit = CW'(m_credit);
      end else begin
        v = quarter ? 5 : dime ? 2 : nickel ? 1 : 0;
        b = (ncoin > 1);
        if (v != 0) begin
          if (m_credit + v > MAXC) b = 1;
          else m_credit += v;
        end
        nxt.credit = CW'(m_credit);
      end
      nxt.bounce  = b;
      nxt.short_f = s;
      m_pend = (m_pend & ~clr) | fall;
      cur = nxt;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cyc_credit", 8'(credit), 8'(cur.credit));
      chk("cyc_vend", 8'(vend), 8'(cur.vend));
      chk("cyc_short", 8'(short_funds), 8'(cur.short_f));
      chk("cyc_bounce", 8'(coin_bounce), 8'(cur.bounce));
      chk("cyc_eq", 8'(eject_q), 8'(cur.eq));
      chk("cyc_ed", 8'(eject_d), 8'(cur.ed));
      chk("cyc_en", 8'(eject_n), 8'(cur.en));
      chk("cyc_busy", 8'(busy), 8'(cur.busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit q, input bit d, input bit n, input bit b, input logic [CW-1:0] p);
    quarter = q; dime = d; nickel = n; buy = b; price = p;
    @(posedge clk);
    #2;
    quarter = 0; dime = 0; nickel = 0; buy = 0;
    $display("step q=%0d d=%0d n=%0d buy=%0d price=%0d -> credit=%0d vend=%0d short=%0d bounce=%0d ej=%0d%0d%0d busy=%0d",
             q, d, n, b, p, credit, vend, short_funds, coin_bounce, eject_q, eject_d, eject_n, busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy && i < 200) begin
      step(0, 0, 0, 0, '0);
      i++;
    end
    chk(name, 8'(busy), 8'd0);
  endtask

  initial begin
    int qc, dc, nc, bc;
    #1 reset = 1;
    #1 run_cmp = 1;
    @(posedge clk); @(posedge clk); #2 reset = 0;
    chk("reset_credit", 8'(credit), 8'd0);
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_eject_q", 8'(eject_q), 8'd0);

    // Coins on separate cycles.
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    step(0, 0, 1, 0, '0);
    chk("coins_credit", 8'(credit), 8'd8);
    chk("coins_bounce", 8'(coin_bounce), 8'd0);

    // Refund of 8 units: quarter, dime, nickel.
    refund = 1; step(0, 0, 0, 0, '0);
    refund = 0; step(0, 0, 0, 0, '0);
    qc = 0; dc = 0; nc = 0; bc = 0;
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 0, 0, '0);
      qc += int'(eject_q); dc += int'(eject_d); nc += int'(eject_n); bc += int'(busy);
      if (i == 0) chk("refund_first_q", 8'(eject_q), 8'd1);
    end
    chk("refund_q_cycles", 8'(qc), 8'd2);
    chk("refund_d_cycles", 8'(dc), 8'd2);
    chk("refund_n_cycles", 8'(nc), 8'd2);
    chk("refund_busy_cycles", 8'(bc), 8'd12);
    chk("refund_credit", 8'(credit), 8'd0);

    // Short funds, then exact purchase.
    step(0, 1, 0, 0, '0);
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 1, 6'd5);
    chk("short_pulse", 8'(short_funds), 8'd1);
    chk("short_credit", 8'(credit), 8'd3);
    step(0, 0, 0, 0, '0);
    chk("short_one_cycle", 8'(short_funds), 8'd0);
    step(0, 0, 0, 1, 6'd3);
    chk("vend_pulse", 8'(vend), 8'd1);
    chk("vend_credit", 8'(credit), 8'd0);
    step(0, 0, 0, 0, '0);
    chk("vend_one_cycle", 8'(vend), 8'd0);

    // Simultaneous coins and the overflow boundary.
    step(1, 0, 1, 0, '0);
    chk("multi_credit", 8'(credit), 8'd5);
    chk("multi_bounce", 8'(coin_bounce), 8'd1);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    chk("fill_credit", 8'(credit), 8'd62);
    step(0, 1, 0, 0, '0);
    chk("ovf_bounce", 8'(coin_bounce), 8'd1);
    chk("ovf_credit", 8'(credit), 8'd62);
    step(0, 0, 1, 0, '0);
    chk("max_credit", 8'(credit), 8'd63);
    step(0, 0, 1, 0, '0);
    chk("max_bounce", 8'(coin_bounce), 8'd1);

    // Refund edge while in VEND.
    refund = 1; step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 6'd3);
    chk("vend2_pulse", 8'(vend), 8'd1);
    refund = 0; step(0, 0, 0, 0, '0);
`ifndef AUTO_CHANGE_EN
    chk("vend2_back_idle", 8'(busy), 8'd0);
    step(0, 0, 0, 0, '0);
`endif
    chk("vend2_eject_q", 8'(eject_q), 8'd1);
    chk("vend2_credit", 8'(credit), 8'd55);
    step(1, 0, 0, 0, '0);
    chk("eject_coin_bounce", 8'(coin_bounce), 8'd1);
    chk("eject_coin_credit", 8'(credit), 8'd55);
    step(0, 0, 0, 1, 6'd1);
    chk("eject_buy_ignored", 8'(short_funds | vend), 8'd0);
    wait_idle("vend2_timeout");
    chk("vend2_final_credit", 8'(credit), 8'd0);

    // Reset in the middle of an eject_q pulse.
    step(1, 0, 0, 0, '0);
    refund = 1; step(0, 0, 0, 0, '0);
    refund = 0; step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("pre_reset_eject_q", 8'(eject_q), 8'd1);
    #1 reset = 1;
    #1;
    chk("async_eject_q", 8'(eject_q), 8'd0);
    chk("async_credit", 8'(credit), 8'd0);
    chk("async_busy", 8'(busy), 8'd0);
    @(posedge clk); #2 reset = 0;

    // Vend with change left over.
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 1, 6'd2);
    chk("chg_vend", 8'(vend), 8'd1);
    chk("chg_credit", 8'(credit), 8'd5);
    step(0, 0, 0, 0, '0);
`ifdef AUTO_CHANGE_EN
    chk("chg_auto_eject_q", 8'(eject_q), 8'd1);
    chk("chg_auto_credit", 8'(credit), 8'd0);
    wait_idle("chg_timeout");
`else
    chk("chg_no_eject", 8'(eject_q), 8'd0);
    chk("chg_kept_credit", 8'(credit), 8'd5);
`endif
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
